// File: rtl/arcade_input_ctrl_if.sv
// ioctl download bus from hps_io into arcade_input_ctrl.
// The master drives the download strobe, index, address and data; the slave only samples them.
interface arcade_input_ctrl_if;
   logic        ioctl_wr;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;

   modport master (
      output ioctl_wr,
      output ioctl_index,
      output ioctl_addr,
      output ioctl_dout
   );

   modport slave (
      input ioctl_wr,
      input ioctl_index,
      input ioctl_addr,
      input ioctl_dout
   );
endinterface

// File: rtl/arcade_input_ctrl.sv
// Arcade input front end: PS/2 + joystick merge, coin pulse stretcher, DIP/SYSMODE latches.
// Optional autofire on player T1 buttons when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_ctrl #(
   parameter int unsigned NPLAYERS   = 2,
   parameter int unsigned NDSW       = 8,
   parameter logic [15:0] COIN_PULSE = 16'd4800,
   parameter logic [15:0] COIN_GAP   = 16'd4800
`ifdef ARCADE_INPUT_AUTOFIRE_EN
   ,
   parameter logic [19:0] AUTOFIRE_DIV = 20'd400000
`endif
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic [10:0]            ps2_key,
   input  logic [NPLAYERS*16-1:0] joystick,
   input  logic                   cabinet,
   arcade_input_ctrl_if.slave     ioctl,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
   input  logic                   autofire_on,
`endif
   output logic [NPLAYERS*8-1:0]  inp_player,
   output logic [7:0]             inp_sys,
   output logic [NDSW*8-1:0]      dsw,
   output logic [7:0]             sysmode,
   output logic                   coin_busy
);

   typedef struct packed {
      logic p1_u, p1_d, p1_l, p1_r, p1_t1, p1_t2;
      logic f1, f2, st1, st2, coin1, coin2;
      logic p2_u, p2_d, p2_l, p2_r, p2_t1, p2_t2;
   } keys_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } coin_state_t;

   keys_t            keys;
   logic             toggle_q;
   logic [63:0]      joy_pad;
   logic             unused_joy;
   logic [3:0][7:0]  pl;
   logic [31:0]      pl_flat;
   logic [3:0]       st_nxt;
   logic [3:0]       st_q;
   logic             coin_raw;
   logic             coin_raw_q;
   logic             coin_rise;
   logic             af_gate;
   coin_state_t      state;
   coin_state_t      state_nxt;
   logic [15:0]      cnt;
   logic [15:0]      cnt_nxt;

   // Players beyond NPLAYERS read as released so fixed bit positions stay legal.
   assign joy_pad    = 64'(joystick);
   assign unused_joy = ^joy_pad;

   // Joystick word -> active-high {L,R,U,D,0,T2,T1,0}.
   function automatic logic [7:0] joy_to_pl(input logic [15:0] j);
      return {j[1], j[0], j[3], j[2], 1'b0, j[5], j[4], 1'b0};
   endfunction

   // ---------------------------------------------------------------- PS/2 keys
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         toggle_q <= 1'b0;
         keys     <= '0;
      end else begin
         toggle_q <= ps2_key[10];
         if (ps2_key[10] != toggle_q) begin
            casez (ps2_key[8:0])
               9'b?_0111_0101: keys.p1_u  <= ps2_key[9];
               9'b?_0111_0010: keys.p1_d  <= ps2_key[9];
               9'b?_0110_1011: keys.p1_l  <= ps2_key[9];
               9'b?_0111_0100: keys.p1_r  <= ps2_key[9];
               9'h029:         keys.p1_t1 <= ps2_key[9];
               9'h014:         keys.p1_t2 <= ps2_key[9];
               9'h005:         keys.f1    <= ps2_key[9];
               9'h006:         keys.f2    <= ps2_key[9];
               9'h016:         keys.st1   <= ps2_key[9];
               9'h01E:         keys.st2   <= ps2_key[9];
               9'h02E:         keys.coin1 <= ps2_key[9];
               9'h036:         keys.coin2 <= ps2_key[9];
               9'h02D:         keys.p2_u  <= ps2_key[9];
               9'h02B:         keys.p2_d  <= ps2_key[9];
               9'h023:         keys.p2_l  <= ps2_key[9];
               9'h034:         keys.p2_r  <= ps2_key[9];
               9'h01C:         keys.p2_t1 <= ps2_key[9];
               9'h01B:         keys.p2_t2 <= ps2_key[9];
               default: ;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- autofire
`ifdef ARCADE_INPUT_AUTOFIRE_EN
   logic [19:0] af_cnt;
   logic        af_ph;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         af_cnt <= '0;
         af_ph  <= 1'b0;
      end else if (af_cnt == AUTOFIRE_DIV - 20'd1) begin
         af_cnt <= '0;
         af_ph  <= ~af_ph;
      end else begin
         af_cnt <= af_cnt + 20'd1;
      end
   end

   assign af_gate = ~autofire_on | af_ph;
`else
   assign af_gate = 1'b1;
`endif

   // ---------------------------------------------------------------- merge
   always_comb begin
      pl    = '0;
      pl[1] = {keys.p2_l, keys.p2_r, keys.p2_u, keys.p2_d, 1'b0, keys.p2_t2, keys.p2_t1, 1'b0}
              | joy_to_pl(joy_pad[31:16]);
      pl[0] = {keys.p1_l, keys.p1_r, keys.p1_u, keys.p1_d, 1'b0, keys.p1_t2, keys.p1_t1, 1'b0}
              | joy_to_pl(joy_pad[15:0]) | (cabinet ? 8'h00 : pl[1]);
      pl[2] = joy_to_pl(joy_pad[47:32]);
      pl[3] = joy_to_pl(joy_pad[63:48]);
      pl[0][1] = pl[0][1] & af_gate;
      pl[1][1] = pl[1][1] & af_gate;
      pl[2][1] = pl[2][1] & af_gate;
      pl[3][1] = pl[3][1] & af_gate;
   end

   assign pl_flat = pl;

   assign st_nxt[0] = keys.f1 | keys.st1 | joy_pad[6] | joy_pad[22] | joy_pad[38] | joy_pad[54];
   assign st_nxt[1] = keys.f2 | keys.st2 | joy_pad[7] | joy_pad[23] | joy_pad[39] | joy_pad[55];
   assign st_nxt[2] = joy_pad[38];
   assign st_nxt[3] = joy_pad[54];

   assign coin_raw = keys.f1 | keys.f2 | keys.coin1 | keys.coin2
                     | joy_pad[8] | joy_pad[24] | joy_pad[40] | joy_pad[56];
   assign coin_rise = coin_raw & ~coin_raw_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         inp_player <= '1;
         st_q       <= '0;
         coin_raw_q <= 1'b0;
      end else begin
         inp_player <= ~pl_flat[NPLAYERS*8-1:0];
         st_q       <= st_nxt;
         coin_raw_q <= coin_raw;
      end
   end

   // ---------------------------------------------------------------- coin FSM
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (coin_rise) begin
               state_nxt = PULSE;
               cnt_nxt   = COIN_PULSE - 16'd1;
            end
         end
         PULSE: begin
            if (cnt == '0) begin
               state_nxt = GAP;
               cnt_nxt   = COIN_GAP - 16'd1;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         GAP: begin
            if (cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // COIN decodes straight from the state register so reset releases it asynchronously.
   assign coin_busy = (state != IDLE);
   assign inp_sys   = {~st_q, 3'b111, ~(state == PULSE)};

   // ---------------------------------------------------------------- ioctl latches
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sysmode <= '0;
      end else if (ioctl.ioctl_wr && ioctl.ioctl_index == 8'd1 && ioctl.ioctl_addr == '0) begin
         sysmode <= ioctl.ioctl_dout;
      end
   end

   for (genvar g = 0; g < NDSW; g++) begin : g_dsw
      logic [7:0] bank_q;

      always_ff @(posedge clk_sys or negedge reset_n) begin
         if (!reset_n) begin
            bank_q <= '1;
         end else if (ioctl.ioctl_wr && ioctl.ioctl_index == 8'd254
                      && ioctl.ioctl_addr == 25'(g)) begin
            bank_q <= ioctl.ioctl_dout;
         end
      end

      assign dsw[g*8 +: 8] = bank_q;
   end

endmodule
